spidergon_vc_input_unit: RTL
============================

Name: spidergon_vc_input_unit

Overview:
Parametrised input port of a spidergon router node. It holds one FIFO per virtual channel and computes the route per packet using the spidergon across-first shortest-path rule. It arbitrates VCs round-robin onto a single wormhole-locked output and returns credits upstream. Each node instantiates three of these, one each for the ACROSS, CLOCKWISE and ANTI_CLOCKWISE inputs, ahead of the crossbar.

Parameters:
NUM_OF_NODES, 8, ring size; must be even and >=4
FLIT_DATA_WIDTH, 16, payload width; FLIT_TOTAL_WIDTH = 2 + FLIT_DATA_WIDTH
NUM_OF_VIRTUAL_CHANNELS, 2, VCs on this port (>=1)
VC_BUFFER_DEPTH, 4, flits per VC FIFO (>=2)
NODE_IDENTIFIER, 0, this node's address, 0..NUM_OF_NODES-1
Derived: DEST_NODE_WIDTH = $clog2(NUM_OF_NODES); VC_WIDTH = max(1, $clog2(NUM_OF_VIRTUAL_CHANNELS))

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
flit_in_valid  in  1  flit present on flit_in
flit_in_vc  in  VC_WIDTH  target VC of flit_in
flit_in  in  FLIT_TOTAL_WIDTH  [MSB-:2] type (01 head, 10 body, 00 tail, 11 single-flit header); dest = [FLIT_DATA_WIDTH-1 -: DEST_NODE_WIDTH]
credit_valid  out  1  one flit freed upstream
credit_vc  out  VC_WIDTH  VC of freed slot
flit_out_valid  out  1  flit offered to crossbar
flit_out_ready  in  1  crossbar accepts flit
flit_out  out  FLIT_TOTAL_WIDTH  flit forwarded unchanged
flit_out_vc  out  VC_WIDTH  source VC of flit_out
flit_out_dir  out  2  STOP=3, ACROSS=2, CLOCKWISE=1, ANTI_CLOCKWISE=0
vc_occupancy  out  NUM_OF_VIRTUAL_CHANNELS*($clog2(VC_BUFFER_DEPTH)+1)  per-VC flit count, VC0 in LSBs
overflow_error  out  1  sticky: push to a full VC
protocol_error  out  1  sticky: body/tail without head, or head inside an open packet

Behaviour:
- Reset (sync): all FIFOs empty, all VC states IDLE, no output lock, RR pointer = 0. Every output is 0: flit_out_valid, credit_valid, both error flags, occupancy, flit_out, flit_out_vc, flit_out_dir.
- Push: flit_in_valid writes to FIFO[flit_in_vc] at the clock edge.
  - Accepted if count < DEPTH, or if the same VC pops in the same cycle.
  - Otherwise the flit is dropped and overflow_error is set.
  - flit_in_vc >= NUM_OF_VIRTUAL_CHANNELS: flit dropped, protocol_error set.
- Latency: a flit pushed at edge t is visible at the FIFO head at t+1. flit_out_valid can assert in cycle t+1 at the earliest. There is no bypass.
- Per-VC FSM, driven by the flit at the FIFO head:
  - IDLE: head at FIFO head -> compute route, latch dir -> ACTIVE.
  - IDLE: type 11 -> route, single-flit packet, returns to IDLE after its pop.
  - IDLE: body/tail at FIFO head -> flit discarded (popped, credit returned), protocol_error set.
  - ACTIVE: body flits forward with the latched dir. The tail pop returns the VC to IDLE.
  - ACTIVE: head/11 at FIFO head -> protocol_error set. The flit is treated as the tail of the old packet, then re-examined as the new head.
- Route: rel = (dest - NODE_IDENTIFIER) mod NUM_OF_NODES; Q = NUM_OF_NODES/4 (integer).
  - rel = 0 -> STOP.
  - 1 <= rel <= Q -> CLOCKWISE.
  - rel >= NUM_OF_NODES - Q -> ANTI_CLOCKWISE.
  - Otherwise -> ACROSS.
- Arbitration:
  - When unlocked, grant the first eligible VC (non-empty, with a routable head) at or after the RR pointer.
  - A head grant locks the output to that VC until its tail (or single-flit 11) pops. Flits from different packets never interleave on flit_out.
  - On unlock, the RR pointer moves to granted VC + 1, wrapping.
- Output handshake:
  - flit_out, flit_out_vc and flit_out_dir stay stable while flit_out_valid && !flit_out_ready.
  - Pop occurs iff flit_out_valid && flit_out_ready.
  - If the locked VC's FIFO empties mid-packet, flit_out_valid drops and the lock is held.
- Credit: credit_valid = 1 for exactly one cycle, registered, in the cycle after each pop or discard, with credit_vc = that VC. Dropped pushes return no credit.
- Reset mid-packet: all buffered flits are lost, no credits are returned, and locks are cleared. Upstream is reset in the same cycle.

Test Plan:
1. NODE_IDENTIFIER=0, N=8; single-flit 11 flits to dest 0,1,2,3,4,5,6,7 on VC0 -> flit_out_dir = 3,1,1,2,2,2,0,0. First flit_out_valid appears 1 cycle after push.
2. Three-flit packets (head, body, tail) interleaved on VC0 and VC1, flit_out_ready=1 -> each packet leaves contiguously; VC0 packet first, then VC1. credit_valid pulses 6 times, each 1 cycle after its pop.
3. DEPTH=4; push 5 flits to VC1 with flit_out_ready=0 -> occupancy[VC1]=4, overflow_error=1. The 5th flit never appears on flit_out.
4. Hold flit_out_ready=0 for 3 cycles mid-packet -> flit_out, flit_out_vc and flit_out_dir are unchanged; no credit until ready rises.
5. Body flit pushed into an IDLE VC -> discarded; protocol_error=1; one credit returned; flit_out_valid stays 0.
6. Assert reset with 2 flits buffered -> next cycle flit_out_valid=0, occupancy=0, errors=0, credit_valid=0.

Source files
------------

// File: rtl/spidergon_vc_input_unit.sv
// Spidergon router input port: per-VC flit FIFOs, across-first route computation,
// round-robin wormhole arbitration onto one output, and upstream credit return.
module spidergon_vc_input_unit #(
  parameter int NUM_OF_NODES            = 8,
  parameter int FLIT_DATA_WIDTH         = 16,
  parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
  parameter int VC_BUFFER_DEPTH         = 4,
  parameter int NODE_IDENTIFIER         = 0,
  localparam int FLIT_TOTAL_WIDTH = 2 + FLIT_DATA_WIDTH,
  localparam int DEST_NODE_WIDTH  = $clog2(NUM_OF_NODES),
  localparam int VC_WIDTH         = (NUM_OF_VIRTUAL_CHANNELS > 1) ? $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1,
  localparam int OCC_WIDTH        = $clog2(VC_BUFFER_DEPTH) + 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         flit_in_valid,
  input  logic [VC_WIDTH-1:0]                          flit_in_vc,
  input  logic [FLIT_TOTAL_WIDTH-1:0]                  flit_in,
  output logic                                         credit_valid,
  output logic [VC_WIDTH-1:0]                          credit_vc,
  output logic                                         flit_out_valid,
  input  logic                                         flit_out_ready,
  output logic [FLIT_TOTAL_WIDTH-1:0]                  flit_out,
  output logic [VC_WIDTH-1:0]                          flit_out_vc,
  output logic [1:0]                                   flit_out_dir,
  output logic [NUM_OF_VIRTUAL_CHANNELS*OCC_WIDTH-1:0] vc_occupancy,
  output logic                                         overflow_error,
  output logic                                         protocol_error
);

  localparam int NV        = NUM_OF_VIRTUAL_CHANNELS;
  localparam int PTR_WIDTH = $clog2(VC_BUFFER_DEPTH);
  localparam int QUARTER   = NUM_OF_NODES / 4;

  localparam logic [1:0] TYPE_HEAD   = 2'b01;
  localparam logic [1:0] TYPE_BODY   = 2'b10;
  localparam logic [1:0] TYPE_TAIL   = 2'b00;
  localparam logic [1:0] TYPE_SINGLE = 2'b11;

  localparam logic [1:0] DIR_STOP   = 2'd3;
  localparam logic [1:0] DIR_ACROSS = 2'd2;
  localparam logic [1:0] DIR_CW     = 2'd1;
  localparam logic [1:0] DIR_ACW    = 2'd0;

  typedef enum logic {VC_IDLE, VC_ACTIVE} vc_state_t;

  function automatic logic [1:0] route(input logic [DEST_NODE_WIDTH-1:0] dest);
    int rel;
    rel = (int'(dest) + NUM_OF_NODES - NODE_IDENTIFIER) % NUM_OF_NODES;
    if (rel == 0)                           return DIR_STOP;
    else if (rel <= QUARTER)                return DIR_CW;
    else if (rel >= NUM_OF_NODES - QUARTER) return DIR_ACW;
    else                                    return DIR_ACROSS;
  endfunction

  function automatic logic [VC_WIDTH-1:0] next_vc(input logic [VC_WIDTH-1:0] v);
    if (int'(v) >= NV - 1) return '0;
    else                   return v + 1'b1;
  endfunction

  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
    if (p == PTR_WIDTH'(VC_BUFFER_DEPTH - 1)) return '0;
    else                                       return p + 1'b1;
  endfunction

  logic [FLIT_TOTAL_WIDTH-1:0] mem [NV][VC_BUFFER_DEPTH];
  logic [PTR_WIDTH-1:0]        rd_ptr [NV];
  logic [PTR_WIDTH-1:0]        wr_ptr [NV];
  logic [OCC_WIDTH-1:0]        count  [NV];

  vc_state_t            state_q [NV];
  vc_state_t            state_d [NV];
  logic [1:0]           dir_q   [NV];
  logic [1:0]           dir_d   [NV];
  logic                 lock_q, lock_d;
  logic [VC_WIDTH-1:0]  lock_vc_q, lock_vc_d;
  logic [VC_WIDTH-1:0]  rr_q, rr_d;

  logic [FLIT_TOTAL_WIDTH-1:0] head_flit  [NV];
  logic [1:0]                  head_type  [NV];
  logic [1:0]                  head_route [NV];
  logic [NV-1:0]               not_empty, head_is_hdr, eligible;

  logic                grant_found, discard_found, do_discard;
  logic [VC_WIDTH-1:0] grant_vc, discard_vc, sel_vc, pop_vc, in_idx;
  logic                restart, offer, out_pop, pop_any;
  logic                in_vc_ok, push_ok;
  logic [1:0]          sel_dir;
  logic [NV-1:0]       push_v, pop_v;

  // NOTE: every variable assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    for (int v = 0; v < NV; v++) begin
      head_flit[v]  = mem[v][rd_ptr[v]];
      head_type[v]  = head_flit[v][FLIT_TOTAL_WIDTH-1 -: 2];
      head_route[v] = route(head_flit[v][FLIT_DATA_WIDTH-1 -: DEST_NODE_WIDTH]);
      not_empty[v]  = (count[v] != '0);
      // Head (01) and single-flit (11) share the low type bit.
      head_is_hdr[v] = head_type[v][0];
      eligible[v]    = not_empty[v] && (state_q[v] == VC_IDLE) && head_is_hdr[v];
    end
  end

  always_comb begin
    int idx;
    grant_found   = 1'b0;
    grant_vc      = '0;
    discard_found = 1'b0;
    discard_vc    = '0;
    for (int k = 0; k < NV; k++) begin
      idx = (int'(rr_q) + k) % NV;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_vc    = VC_WIDTH'(idx);
      end
    end
    for (int v = 0; v < NV; v++) begin
      if (!discard_found && not_empty[v] && (state_q[v] == VC_IDLE) && !head_is_hdr[v]) begin
        discard_found = 1'b1;
        discard_vc    = VC_WIDTH'(v);
      end
    end
  end

  always_comb begin
    sel_vc  = lock_q ? lock_vc_q : grant_vc;
    // A header arriving inside an open packet closes that packet without being popped.
    restart = lock_q && (state_q[lock_vc_q] == VC_ACTIVE) && not_empty[lock_vc_q] && head_is_hdr[lock_vc_q];
    offer   = lock_q ? (not_empty[sel_vc] && !restart) : grant_found;
    out_pop = offer && flit_out_ready;
    sel_dir = (state_q[sel_vc] == VC_ACTIVE) ? dir_q[sel_vc] : head_route[sel_vc];
    // One pop per cycle keeps the single credit port sufficient.
    do_discard = discard_found && !out_pop;
    pop_any    = out_pop || do_discard;
    pop_vc     = out_pop ? sel_vc : discard_vc;
    in_vc_ok   = int'(flit_in_vc) < NV;
    in_idx     = in_vc_ok ? flit_in_vc : '0;
    push_ok    = flit_in_valid && in_vc_ok &&
                 ((count[in_idx] != OCC_WIDTH'(VC_BUFFER_DEPTH)) || (pop_any && (pop_vc == flit_in_vc)));
    push_v = '0;
    pop_v  = '0;
    if (push_ok) push_v[in_idx] = 1'b1;
    if (pop_any) pop_v[pop_vc]  = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    lock_d    = lock_q;
    lock_vc_d = lock_vc_q;
    rr_d      = rr_q;
    if (restart) begin
      state_d[lock_vc_q] = VC_IDLE;
      lock_d             = 1'b0;
      rr_d               = next_vc(lock_vc_q);
    end else if (out_pop) begin
      case (head_type[sel_vc])
        TYPE_HEAD: begin
          state_d[sel_vc] = VC_ACTIVE;
          dir_d[sel_vc]   = sel_dir;
          lock_d          = 1'b1;
          lock_vc_d       = sel_vc;
        end
        TYPE_TAIL, TYPE_SINGLE: begin
          state_d[sel_vc] = VC_IDLE;
          lock_d          = 1'b0;
          rr_d            = next_vc(sel_vc);
        end
        TYPE_BODY: ;
        default: ;
      endcase
    end else if (offer && !lock_q) begin
      // Hold the grant while stalled so the offered flit cannot change under backpressure.
      lock_d    = 1'b1;
      lock_vc_d = sel_vc;
    end
  end

  always_comb begin
    flit_out_valid = offer;
    flit_out       = offer ? head_flit[sel_vc] : '0;
    flit_out_vc    = offer ? sel_vc : '0;
    flit_out_dir   = offer ? sel_dir : '0;
    for (int v = 0; v < NV; v++) vc_occupancy[v*OCC_WIDTH +: OCC_WIDTH] = count[v];
  end

  // NOTE: flit storage has no reset; counts and pointers define validity and outputs are gated by offer.
  always_ff @(posedge clk) begin
    if (push_ok) mem[in_idx][wr_ptr[in_idx]] <= flit_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NV; v++) begin
        rd_ptr[v]  <= '0;
        wr_ptr[v]  <= '0;
        count[v]   <= '0;
        state_q[v] <= VC_IDLE;
        dir_q[v]   <= DIR_ACW;
      end
      lock_q         <= 1'b0;
      lock_vc_q      <= '0;
      rr_q           <= '0;
      credit_valid   <= 1'b0;
      credit_vc      <= '0;
      overflow_error <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      for (int v = 0; v < NV; v++) begin
        if (push_v[v]) wr_ptr[v] <= next_ptr(wr_ptr[v]);
        if (pop_v[v])  rd_ptr[v] <= next_ptr(rd_ptr[v]);
        case ({push_v[v], pop_v[v]})
          2'b10:   count[v] <= count[v] + 1'b1;
          2'b01:   count[v] <= count[v] - 1'b1;
          default: ;
        endcase
        state_q[v] <= state_d[v];
        dir_q[v]   <= dir_d[v];
      end
      lock_q         <= lock_d;
      lock_vc_q      <= lock_vc_d;
      rr_q           <= rr_d;
      credit_valid   <= pop_any;
      credit_vc      <= pop_any ? pop_vc : '0;
      overflow_error <= overflow_error | (flit_in_valid && in_vc_ok && !push_ok);
      protocol_error <= protocol_error | (flit_in_valid && !in_vc_ok) | do_discard | restart;
    end
  end

endmodule
